// File: rtl/hs_stream_pkt_pkg.sv
// Shared types for the packet-length-limit stream stage.
package hs_stream_pkt_pkg;

    // Pass words through, or drop the tail of an over-length packet
    typedef enum logic {
        S_PASS    = 1'b0,
        S_DISCARD = 1'b1
    } pkt_lim_state_e;

endpackage

// File: rtl/hs_stream_fwd_reg.sv
// Single-stage valid/ready forward register carrying a data word plus sideband.
// Full throughput: a new word may load in the same cycle the held word drains.
module hs_stream_fwd_reg
    import hs_stream_pkt_pkg::*;
#(
    parameter type DATA_T = logic,
    parameter type SIDE_T = logic
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    output logic  can_load,
    input  DATA_T load_data,
    input  SIDE_T load_side,
    output logic  valid,
    input  logic  ready,
    output DATA_T data,
    output SIDE_T side
);

    // Register is free when empty or when its word leaves this cycle
    assign can_load = !valid || ready;

    // Output register; contents hold while valid && !ready
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            side  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            side  <= load_side;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hs_stream_pkt_len_limit.sv
// Packet length limiter on a valid/ready/last stream, fed by an async FIFO read port.
// Packets longer than MAX_PKT_LEN are cut at word MAX_PKT_LEN (forced last, flagged
// trunc) and the rest of the source packet is swallowed. Each output last beat
// carries the packet word count.
// Optional build macro HS_PKT_LEN_LIMIT_STATS_EN adds saturating packet/truncation
// counters; without it the stat ports read 0 and no counter flops exist.
module hs_stream_pkt_len_limit
    import hs_stream_pkt_pkg::*;
#(
    parameter type         DATA_TYPE   = logic,
    parameter int unsigned MAX_PKT_LEN = 256,
    parameter int unsigned STAT_WIDTH  = 16,
    localparam int unsigned LEN_WIDTH  = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                  dst_clk,
    input  logic                  dst_rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  DATA_TYPE              s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output DATA_TYPE              m_data,
    output logic                  m_last,
    output logic                  m_trunc,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic [STAT_WIDTH-1:0] stat_pkt_cnt,
    output logic [STAT_WIDTH-1:0] stat_trunc_cnt
);

    // Sideband travelling with each output word
    typedef struct packed {
        logic                 last;
        logic                 trunc;
        logic [LEN_WIDTH-1:0] len;
    } pkt_side_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);

    pkt_lim_state_e       state;
    pkt_lim_state_e       state_nxt;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic [LEN_WIDTH-1:0] word_cnt_nxt;
    logic [LEN_WIDTH-1:0] word_cnt_inc;
    logic                 can_load;
    logic                 load;
    pkt_side_t            load_side;
    pkt_side_t            side;

    // word_cnt stays below MAX_PKT_LEN, so the increment never wraps
    assign word_cnt_inc = word_cnt + LEN_WIDTH'(1);

    // State and word counter registers
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            state    <= S_PASS;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    // Next state, word count, load strobe and sideband for the loaded word
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        load         = 1'b0;
        load_side    = '0;
        s_ready      = can_load;
        case (state)
            S_PASS: begin
                if (s_valid && can_load) begin
                    load = 1'b1;
                    if (s_last) begin
                        load_side.last = 1'b1;
                        load_side.len  = word_cnt_inc;
                        word_cnt_nxt   = '0;
                    end else if (word_cnt_inc == MAX_LEN) begin
                        load_side.last  = 1'b1;
                        load_side.trunc = 1'b1;
                        load_side.len   = MAX_LEN;
                        word_cnt_nxt    = '0;
                        state_nxt       = S_DISCARD;
                    end else begin
                        word_cnt_nxt = word_cnt_inc;
                    end
                end
            end
            S_DISCARD: begin
                // Tail words are always taken and dropped
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_nxt = S_PASS;
                end
            end
            default: begin
                state_nxt = S_PASS;
            end
        endcase
    end

    hs_stream_fwd_reg #(
        .DATA_T (DATA_TYPE),
        .SIDE_T (pkt_side_t)
    ) u_fwd_reg (
        .clk       (dst_clk),
        .rst       (dst_rst),
        .load      (load),
        .can_load  (can_load),
        .load_data (s_data),
        .load_side (load_side),
        .valid     (m_valid),
        .ready     (m_ready),
        .data      (m_data),
        .side      (side)
    );

    assign m_last  = side.last;
    assign m_trunc = side.trunc;
    assign m_len   = side.len;

`ifdef HS_PKT_LEN_LIMIT_STATS_EN
    logic [STAT_WIDTH-1:0] pkt_cnt;
    logic [STAT_WIDTH-1:0] trunc_cnt;
    logic                  pkt_done;

    assign pkt_done = m_valid && m_ready && side.last;

    // Saturating counters of completed and truncated output packets
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (pkt_done && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + STAT_WIDTH'(1);
            end
            if (pkt_done && side.trunc && (trunc_cnt != '1)) begin
                trunc_cnt <= trunc_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt;
    assign stat_trunc_cnt = trunc_cnt;
`else
    assign stat_pkt_cnt   = '0;
    assign stat_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_hs_stream_pkt_len_limit.sv
// Bench for hs_stream_pkt_len_limit with MAX_PKT_LEN=4, STAT_WIDTH=2:
// directed cycle table, stats sequence, then randomized packets vs a packet-level model.
module tb_hs_stream_pkt_len_limit;

    localparam int unsigned MAXL  = 4;
    localparam int unsigned SW    = 2;
    localparam int unsigned LW    = 3;
    localparam int          LIMIT = 20000;

    typedef logic [7:0] word_t;

    logic          dst_clk = 1'b0;
    logic          dst_rst;
    logic          s_valid;
    logic          s_ready;
    word_t         s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    word_t         m_data;
    logic          m_last;
    logic          m_trunc;
    logic [LW-1:0] m_len;
    logic [SW-1:0] stat_pkt_cnt;
    logic [SW-1:0] stat_trunc_cnt;

    int total = 0;
    int bad   = 0;

    always #5 dst_clk = ~dst_clk;

    hs_stream_pkt_len_limit #(
        .DATA_TYPE   (word_t),
        .MAX_PKT_LEN (MAXL),
        .STAT_WIDTH  (SW)
    ) dut (
        .dst_clk        (dst_clk),
        .dst_rst        (dst_rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_trunc        (m_trunc),
        .m_len          (m_len),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_trunc_cnt (stat_trunc_cnt)
    );

    typedef struct {
        logic          rst;
        logic          v;
        word_t         d;
        logic          l;
        logic          mr;
        logic          sr;
        logic          mv;
        word_t         md;
        logic          ml;
        logic          mt;
        logic [LW-1:0] mlen;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic v, input word_t d, input logic l,
                       input logic mr, input logic sr, input logic mv, input word_t md,
                       input logic ml, input logic mt, input int len);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.mr = mr; r.sr = sr;
        r.mv = mv; r.md = md; r.ml = ml; r.mt = mt; r.mlen = LW'(len);
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge dst_clk);
        dst_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (2) @(posedge dst_clk);
        @(negedge dst_clk);
        dst_rst = 1'b0;
    endtask

    task automatic send_pkt(input int n, input word_t base);
        for (int w = 0; w < n; w++) begin
            @(negedge dst_clk);
            s_valid = 1'b1; s_data = base + word_t'(w); s_last = (w == n - 1); m_ready = 1'b1;
        end
    endtask

    initial begin
        dst_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

        // reset state
        do_reset();
        chk("rst m_valid", 32'(m_valid), 0);
        chk("rst m_last", 32'(m_last), 0);
        chk("rst m_trunc", 32'(m_trunc), 0);
        chk("rst m_len", 32'(m_len), 0);
        chk("rst m_data", 32'(m_data), 0);
        chk("rst stat_pkt_cnt", 32'(stat_pkt_cnt), 0);
        chk("rst stat_trunc_cnt", 32'(stat_trunc_cnt), 0);

        //   rst v  d      l  mr  sr  mv md     ml mt len
        // 3-word packet
        add(0, 1, 8'h10, 0, 1,  1,  1, 8'h10, 0, 0, 0);
        add(0, 1, 8'h11, 0, 1,  1,  1, 8'h11, 0, 0, 0);
        add(0, 1, 8'h12, 1, 1,  1,  1, 8'h12, 1, 0, 3);
        // 7-word packet: cut at word 4, words 5-7 dropped
        add(0, 1, 8'h20, 0, 1,  1,  1, 8'h20, 0, 0, 0);
        add(0, 1, 8'h21, 0, 1,  1,  1, 8'h21, 0, 0, 0);
        add(0, 1, 8'h22, 0, 1,  1,  1, 8'h22, 0, 0, 0);
        add(0, 1, 8'h23, 0, 1,  1,  1, 8'h23, 1, 1, 4);
        add(0, 1, 8'h24, 0, 1,  1,  0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h25, 0, 1,  1,  0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h26, 1, 1,  1,  0, 8'h00, 0, 0, 0);
        // exactly-4-word packet, then a 1-word packet that must pass
        add(0, 1, 8'h30, 0, 1,  1,  1, 8'h30, 0, 0, 0);
        add(0, 1, 8'h31, 0, 1,  1,  1, 8'h31, 0, 0, 0);
        add(0, 1, 8'h32, 0, 1,  1,  1, 8'h32, 0, 0, 0);
        add(0, 1, 8'h33, 1, 1,  1,  1, 8'h33, 1, 0, 4);
        add(0, 1, 8'h40, 1, 1,  1,  1, 8'h40, 1, 0, 1);
        // back-to-back 2-word packets, m_ready toggling
        add(0, 1, 8'h50, 0, 0,  0,  1, 8'h40, 1, 0, 1);
        add(0, 1, 8'h50, 0, 1,  1,  1, 8'h50, 0, 0, 0);
        add(0, 1, 8'h51, 1, 0,  0,  1, 8'h50, 0, 0, 0);
        add(0, 1, 8'h51, 1, 1,  1,  1, 8'h51, 1, 0, 2);
        add(0, 1, 8'h52, 0, 0,  0,  1, 8'h51, 1, 0, 2);
        add(0, 1, 8'h52, 0, 1,  1,  1, 8'h52, 0, 0, 0);
        add(0, 1, 8'h53, 1, 0,  0,  1, 8'h52, 0, 0, 0);
        add(0, 1, 8'h53, 1, 1,  1,  1, 8'h53, 1, 0, 2);
        add(0, 0, 8'h00, 0, 1,  1,  0, 8'h00, 0, 0, 0);
        // reset on word 2 of a packet; next word restarts the count
        add(0, 1, 8'h60, 0, 0,  1,  1, 8'h60, 0, 0, 0);
        add(1, 1, 8'h61, 0, 0,  0,  0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h70, 0, 1,  1,  1, 8'h70, 0, 0, 0);
        add(0, 1, 8'h71, 1, 1,  1,  1, 8'h71, 1, 0, 2);
        add(0, 0, 8'h00, 0, 1,  1,  0, 8'h00, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge dst_clk);
            dst_rst = tbl[i].rst; s_valid = tbl[i].v; s_data = tbl[i].d;
            s_last = tbl[i].l; m_ready = tbl[i].mr;
            #1;
            chk($sformatf("row%0d s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            @(posedge dst_clk);
            #1;
            chk($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            if (tbl[i].mv) begin
                chk($sformatf("row%0d m_data", i), 32'(m_data), 32'(tbl[i].md));
                chk($sformatf("row%0d m_last", i), 32'(m_last), 32'(tbl[i].ml));
                chk($sformatf("row%0d m_trunc", i), 32'(m_trunc), 32'(tbl[i].mt));
                chk($sformatf("row%0d m_len", i), 32'(m_len), 32'(tbl[i].mlen));
            end
        end
        dst_rst = 1'b0;

        // stats: 5 packets, two of them over length
        do_reset();
        send_pkt(1, 8'h80);
        send_pkt(6, 8'h90);
        send_pkt(2, 8'ha0);
        send_pkt(5, 8'hb0);
        send_pkt(3, 8'hc0);
        @(negedge dst_clk);
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge dst_clk);
        #1;
`ifdef HS_PKT_LEN_LIMIT_STATS_EN
        chk("stats pkt_cnt saturated", 32'(stat_pkt_cnt), 3);
        chk("stats trunc_cnt", 32'(stat_trunc_cnt), 2);
`else
        chk("stats pkt_cnt off", 32'(stat_pkt_cnt), 0);
        chk("stats trunc_cnt off", 32'(stat_trunc_cnt), 0);
`endif

        // randomized packets against a packet-level model
        begin
            word_t in_d[$];
            logic  in_l[$];
            word_t ex_d[$];
            logic  ex_l[$];
            logic  ex_t[$];
            int    ex_len[$];
            int    ip = 0;
            int    op = 0;
            int    cyc = 0;
            int    mdl_pk = 0;
            int    mdl_tr = 0;
            logic  cur_v = 1'b0;
            logic  held = 1'b0;
            word_t hold_d = '0;

            for (int p = 0; p < 60; p++) begin
                int n;
                n = int'($urandom_range(1, 9));
                for (int w = 0; w < n; w++) begin
                    word_t d;
                    d = word_t'($urandom);
                    in_d.push_back(d);
                    in_l.push_back(w == n - 1);
                    if (w < int'(MAXL)) begin
                        logic lst;
                        lst = (w == n - 1) || (w == int'(MAXL) - 1);
                        ex_d.push_back(d);
                        ex_l.push_back(lst);
                        ex_t.push_back((w == int'(MAXL) - 1) && (n > int'(MAXL)));
                        ex_len.push_back(lst ? w + 1 : 0);
                    end
                end
            end

            do_reset();
            while ((ip < in_d.size() || op < ex_d.size()) && cyc < LIMIT) begin
                @(negedge dst_clk);
                cyc++;
                if (!cur_v && ip < in_d.size()) cur_v = ($urandom_range(0, 3) != 0);
                s_valid = cur_v;
                s_data  = (ip < in_d.size()) ? in_d[ip] : '0;
                s_last  = (ip < in_l.size()) ? in_l[ip] : 1'b0;
                m_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (held) chk("rand stall m_data stable", 32'(m_data), 32'(hold_d));
                if (m_valid && m_ready) begin
                    if (op < ex_d.size()) begin
                        chk($sformatf("rand beat%0d m_data", op), 32'(m_data), 32'(ex_d[op]));
                        chk($sformatf("rand beat%0d m_last", op), 32'(m_last), 32'(ex_l[op]));
                        chk($sformatf("rand beat%0d m_trunc", op), 32'(m_trunc), 32'(ex_t[op]));
                        chk($sformatf("rand beat%0d m_len", op), 32'(m_len), 32'(ex_len[op]));
                        if (ex_l[op] && mdl_pk < 3) mdl_pk++;
                        if (ex_l[op] && ex_t[op] && mdl_tr < 3) mdl_tr++;
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL rand extra beat: got data %0h want no beat", m_data);
                    end
                    op++;
                    held = 1'b0;
                end else begin
                    held   = m_valid;
                    hold_d = m_data;
                end
                if (s_valid && s_ready) begin
                    ip++;
                    cur_v = 1'b0;
                end
                @(posedge dst_clk);
            end
            total++;
            if (cyc >= LIMIT) begin
                bad++;
                $display("FAIL rand timeout: got %0d of %0d beats", op, ex_d.size());
            end
            s_valid = 1'b0;
            #1;
            chk("rand drained m_valid", 32'(m_valid), 0);
`ifdef HS_PKT_LEN_LIMIT_STATS_EN
            chk("rand stat_pkt_cnt", 32'(stat_pkt_cnt), 32'(mdl_pk));
            chk("rand stat_trunc_cnt", 32'(stat_trunc_cnt), 32'(mdl_tr));
`else
            chk("rand stat_pkt_cnt off", 32'(stat_pkt_cnt), 0);
            chk("rand stat_trunc_cnt off", 32'(stat_trunc_cnt), 0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
